// File: rtl/emu_scan_pkg.sv
// Shared sizing for the emulation-instrumented scan RAM: geometry, chain
// length and the scan counter width.
package emu_scan_pkg;

  localparam int ADDR_WIDTH  = 6;
  localparam int DATA_WIDTH  = 80;
  localparam int SCAN_WIDTH  = 64;
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  // Scan words per memory word, and the log2 used to split the counter into
  // word address and chunk select (chunk count is a power of two here).
  localparam int CHUNKS      = (DATA_WIDTH + SCAN_WIDTH - 1) / SCAN_WIDTH;
  localparam int CHUNK_BITS  = $clog2(CHUNKS);
  localparam int CHAIN_WORDS = DEPTH * CHUNKS;
  // Memory word zero-padded up to a whole number of scan words.
  localparam int PAD_WIDTH   = CHUNKS * SCAN_WIDTH;

  // Counter must reach CHAIN_WORDS+1, where it saturates.
  function automatic int cnt_width(input int words);
    return $clog2(words + 2);
  endfunction

  localparam int CNT_WIDTH = cnt_width(CHAIN_WORDS);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [SCAN_WIDTH-1:0] scan_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/emu_scan_ram_if.sv
// Functional and emulator-control bus of the scan RAM.
// halt     <-> $EMU$HALT        ff_scan/ff_sdi/ff_sdo <-> $EMU$FF$SCAN/SDI/SDO
// ram_scan <-> $EMU$RAM$SCAN    ram_dir <-> $EMU$RAM$DIR
// ram_sdi  <-> $EMU$RAM$SDI     ram_sdo <-> $EMU$RAM$SDO
interface emu_scan_ram_if;
  import emu_scan_pkg::*;

  logic  halt;
  logic  ff_scan;
  scan_t ff_sdi;
  scan_t ff_sdo;
  logic  ram_scan;
  logic  ram_dir;
  scan_t ram_sdi;
  scan_t ram_sdo;
  addr_t raddr;
  word_t rdata;
  logic  wen;
  addr_t waddr;
  word_t wdata;

  // Emulator host / surrounding design side.
  modport master (
    output halt, ff_scan, ff_sdi, ram_scan, ram_dir, ram_sdi,
    output raddr, wen, waddr, wdata,
    input  ff_sdo, ram_sdo, rdata
  );

  // RAM side.
  modport slave (
    input  halt, ff_scan, ff_sdi, ram_scan, ram_dir, ram_sdi,
    input  raddr, wen, waddr, wdata,
    output ff_sdo, ram_sdo, rdata
  );

endinterface

// File: rtl/emu_ram_scan_ctrl.sv
// RAM scan-chain controller: word counter, dump pipeline, load holding
// register and the write-port mux that arbitrates scan loads against
// functional writes.
module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  scan,
  input  logic  dir,
  input  scan_t sdi,
  output scan_t sdo,
  output addr_t scan_raddr,
  input  word_t scan_rdata,
  input  logic  func_we,
  input  addr_t func_waddr,
  input  word_t func_wdata,
  output logic  mem_we,
  output addr_t mem_waddr,
  output word_t mem_wdata
);

  localparam int HOLD_WIDTH = (CHUNKS - 1) * SCAN_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_END    = CNT_WIDTH'(CHAIN_WORDS);
  localparam logic [CNT_WIDTH-1:0]  CNT_SAT    = CNT_WIDTH'(CHAIN_WORDS + 1);
  localparam logic [CHUNK_BITS-1:0] LAST_CHUNK = CHUNK_BITS'(CHUNKS - 1);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sel_valid_q, sel_valid_d;
  addr_t                 sel_addr_q, sel_addr_d;
  logic [CHUNK_BITS-1:0] sel_chunk_q, sel_chunk_d;
  scan_t                 sdo_q, sdo_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;

  logic                  cnt_in_chain;
  logic [CHUNK_BITS-1:0] cnt_chunk;
  addr_t                 cnt_addr;
  logic                  scan_we;
  logic [PAD_WIDTH-1:0]  padded_rdata;
  logic [PAD_WIDTH-1:0]  scan_full;
  logic                  unused_scan_bits;

  // Current scan word index split into word address and chunk select.
  assign cnt_in_chain = (cnt_q < CNT_END);
  assign cnt_chunk    = cnt_q[CHUNK_BITS-1:0];
  assign cnt_addr     = cnt_q[CHUNK_BITS +: ADDR_WIDTH];

  // Word counter: restarts whenever scan drops, saturates one past the chain.
  always_comb begin
    cnt_d = cnt_q;
    if (!scan) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Dump pipeline: stage 1 registers the word select, stage 2 the chunk data.
  always_comb begin
    sel_valid_d  = scan & ~dir & cnt_in_chain;
    sel_addr_d   = cnt_addr;
    sel_chunk_d  = cnt_chunk;
    padded_rdata = PAD_WIDTH'(scan_rdata);
    sdo_d        = '0;
    if (sel_valid_q) begin
      sdo_d = padded_rdata[sel_chunk_q*SCAN_WIDTH +: SCAN_WIDTH];
    end
  end

  // Load: lower chunks go to the holding register, the last chunk commits.
  always_comb begin
    hold_d  = hold_q;
    scan_we = 1'b0;
    if (scan && dir && cnt_in_chain) begin
      if (cnt_chunk == LAST_CHUNK) begin
        scan_we = 1'b1;
      end else begin
        hold_d[cnt_chunk*SCAN_WIDTH +: SCAN_WIDTH] = sdi;
      end
    end
  end

  // Padding bits of the last chunk are dropped on the way into memory.
  assign scan_full        = {sdi, hold_q};
  assign unused_scan_bits = ^scan_full[PAD_WIDTH-1:DATA_WIDTH];

  // Write-port mux: an active scan owns the port and blocks functional writes.
  always_comb begin
    mem_we    = scan_we | (func_we & ~scan);
    mem_waddr = func_waddr;
    mem_wdata = func_wdata;
    if (scan) begin
      mem_waddr = cnt_addr;
      mem_wdata = scan_full[DATA_WIDTH-1:0];
    end
  end

  // Controller state; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_addr_q  <= '0;
      sel_chunk_q <= '0;
      sdo_q       <= '0;
      hold_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sel_valid_q <= sel_valid_d;
      sel_addr_q  <= sel_addr_d;
      sel_chunk_q <= sel_chunk_d;
      sdo_q       <= sdo_d;
      hold_q      <= hold_d;
    end
  end

  assign sdo        = sdo_q;
  assign scan_raddr = sel_addr_q;

endmodule

// File: rtl/emu_scan_ram.sv
// 64 x 80 RAM with asynchronous read, synchronous write and a RAM scan chain
// for checkpoint dump/restore by the emulation host while the design is halted.
module emu_scan_ram
  import emu_scan_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  emu_scan_ram_if.slave bus
);

  word_t mem_q [DEPTH];

  logic  func_we;
  logic  mem_we;
  addr_t mem_waddr;
  word_t mem_wdata;
  addr_t scan_raddr;
  word_t scan_rdata;
  logic  unused_ff_scan;

  // Functional writes are frozen while the emulated design is halted.
  assign func_we = bus.wen & ~bus.halt;

  emu_ram_scan_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .scan       (bus.ram_scan),
    .dir        (bus.ram_dir),
    .sdi        (bus.ram_sdi),
    .sdo        (bus.ram_sdo),
    .scan_raddr (scan_raddr),
    .scan_rdata (scan_rdata),
    .func_we    (func_we),
    .func_waddr (bus.waddr),
    .func_wdata (bus.wdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  // Single write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rdata  = mem_q[bus.raddr];
  assign scan_rdata = mem_q[scan_raddr];

  // No flip-flop scan state in this block.
  assign bus.ff_sdo     = '0;
  assign unused_ff_scan = bus.ff_scan ^ (^bus.ff_sdi);

endmodule

// File: tb/tb_emu_scan_ram.sv
// Self-checking bench for emu_scan_ram: functional read/write, halt blocking,
// dump/restore round trips, padding on load and reset during a dump.
module tb_emu_scan_ram;
  import emu_scan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  emu_scan_ram_if bus ();

  emu_scan_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [79:0] ref_mem    [64];
  logic [79:0] round_data [4][64];
  logic [63:0] saved      [4][128];
  logic [63:0] chain_buf  [128];

  // Expected scan word k from the model memory; zero past the chain end.
  function automatic logic [63:0] chain_word(input int k);
    int a;
    if (k >= 128) return 64'h0;
    a = k / 2;
    if (k % 2 == 0) return ref_mem[a][63:0];
    return {48'h0, ref_mem[a][79:64]};
  endfunction

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic func_write(input int a, input logic [79:0] d);
    bus.waddr = 6'(a);
    bus.wdata = d;
    bus.wen   = 1'b1;
    tick();
    bus.wen   = 1'b0;
    if (!bus.halt && !bus.ram_scan) ref_mem[a] = d;
  endtask

  task automatic read_chk(input string tag, input int a);
    bus.raddr = 6'(a);
    #1;
    chk(tag, bus.rdata, ref_mem[a]);
  endtask

  // Full dump: word k appears after k+2 edges; checks a couple of words past the end.
  task automatic dump_all(input string tag);
    bus.halt     = 1'b1;
    bus.ram_dir  = 1'b0;
    bus.ram_scan = 1'b1;
    for (int e = 1; e <= 132; e++) begin
      tick();
      if (e >= 2) begin
        if (e - 2 < 128) chain_buf[e-2] = bus.ram_sdo;
        chk(tag, bus.ram_sdo, chain_word(e - 2));
      end
    end
    bus.ram_scan = 1'b0;
    tick();
    $display("dump %s done", tag);
  endtask

  // Load chain_buf, then one extra edge with garbage that must be ignored.
  task automatic load_chain(input string tag);
    bus.halt     = 1'b1;
    bus.ram_dir  = 1'b1;
    bus.ram_scan = 1'b1;
    for (int k = 0; k < 128; k++) begin
      bus.ram_sdi = chain_buf[k];
      tick();
    end
    bus.ram_sdi  = {$urandom, $urandom};
    tick();
    bus.ram_scan = 1'b0;
    bus.ram_dir  = 1'b0;
    tick();
    $display("load %s done", tag);
  endtask

  initial begin
    logic [63:0] lo;
    logic [63:0] hi;
    logic [79:0] d;

    bus.halt     = 1'b0;
    bus.ff_scan  = 1'b0;
    bus.ff_sdi   = '0;
    bus.ram_scan = 1'b0;
    bus.ram_dir  = 1'b0;
    bus.ram_sdi  = '0;
    bus.raddr    = '0;
    bus.wen      = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    for (int a = 0; a < 64; a++) ref_mem[a] = 'x;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_ram_sdo", bus.ram_sdo, 80'h0);
    chk("reset_ff_sdo", bus.ff_sdo, 80'h0);
    rst = 1'b0;
    tick();

    // 1: write every address, read back in the cycle after the write edge
    for (int j = 0; j < 64; j++) begin
      d = rand80() ^ {16'(j), 64'(j)};
      func_write(j, d);
      read_chk("write_read", j);
    end
    for (int j = 0; j < 64; j++) read_chk("read_all", j);
    $display("step 1: functional write/read done");

    // 2: halted write is blocked; write during scan is blocked
    bus.halt = 1'b1;
    func_write(5, 80'hA);
    read_chk("halt_block", 5);
    bus.halt     = 1'b0;
    bus.ram_scan = 1'b1;
    func_write(7, rand80());
    bus.ram_scan = 1'b0;
    tick();
    read_chk("scan_block", 7);
    $display("step 2: write blocking done");

    // 3: chain order on a known word
    bus.halt = 1'b0;
    func_write(0, 80'h1234_0000000000000001);
    dump_all("dump_order");
    chk("dump_w0", chain_buf[0], 80'h1);
    chk("dump_w1", chain_buf[1], 80'h1234);
    bus.halt = 1'b0;
    for (int j = 0; j < 64; j += 9) read_chk("dump_no_modify", j);

    // 4: dump four random images, then restore each and read back
    for (int r = 0; r < 4; r++) begin
      bus.halt = 1'b0;
      for (int a = 0; a < 64; a++) begin
        round_data[r][a] = rand80();
        func_write(a, round_data[r][a]);
      end
      dump_all("round_dump");
      for (int k = 0; k < 128; k++) saved[r][k] = chain_buf[k];
    end
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 128; k++) chain_buf[k] = saved[r][k];
      load_chain("restore");
      bus.halt = 1'b0;
      for (int a = 0; a < 64; a++) ref_mem[a] = round_data[r][a];
      for (int a = 0; a < 64; a++) read_chk("restore_read", a);
    end

    // 5: upper bits of odd scan words are ignored on load
    for (int a = 0; a < 64; a++) begin
      lo = {$urandom, $urandom};
      hi = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      chain_buf[2*a]   = lo;
      chain_buf[2*a+1] = hi;
      ref_mem[a] = {hi[15:0], lo};
    end
    load_chain("pad_load");
    bus.halt = 1'b0;
    for (int a = 0; a < 64; a++) read_chk("pad_read", a);

    // 6: reset after 10 dumped words, then rescan from word 0
    bus.halt     = 1'b1;
    bus.ram_dir  = 1'b0;
    bus.ram_scan = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e >= 2) chk("partial_dump", bus.ram_sdo, chain_word(e - 2));
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_sdo", bus.ram_sdo, 80'h0);
    bus.ram_scan = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    dump_all("rescan");
    bus.halt = 1'b0;
    for (int a = 0; a < 64; a++) read_chk("post_reset_read", a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/emu_scan_ram.md
Name: emu_scan_ram

Overview:
- Emulation-instrumented 64 x 80-bit RAM with asynchronous read and synchronous write.
- Adds a 64-bit RAM scan chain, so the emulation host can dump the full memory contents as a checkpoint and restore them while the design is halted.
- Sits inside the emulated DUT and is driven by the emulator's clock, halt, reset and RAM-scan control signals.

Parameters:
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH = 64 words.
- DATA_WIDTH, 80, bits per memory word.
- SCAN_WIDTH, 64, width of the scan data bus.
- CHUNKS, derived: ceil(DATA_WIDTH/SCAN_WIDTH) = 2. Number of scan words per memory word.
- CHAIN_WORDS, derived: depth*CHUNKS = 128. Total scan words per dump or restore.

Ports:
- \$EMU$CLK  in  1  single clock; all state updates on its rising edge.
- \$EMU$DUT$RESET  in  1  reset, asynchronous, active-high.
- \$EMU$HALT  in  1  1 = emulated design frozen; blocks functional writes.
- \$EMU$FF$SCAN  in  1  flip-flop scan enable; unused here (tie 0).
- \$EMU$FF$SDI  in  64  flip-flop scan input; unused.
- \$EMU$FF$SDO  out  64  flip-flop scan output; driven constant 0.
- \$EMU$RAM$SCAN  in  1  RAM scan enable.
- \$EMU$RAM$DIR  in  1  0 = dump (RAM to SDO), 1 = load (SDI to RAM).
- \$EMU$RAM$SDI  in  64  load data.
- \$EMU$RAM$SDO  out  64  dump data (registered).
- raddr  in  6  functional read address.
- rdata  out  80  functional read data.
- wen  in  1  functional write enable.
- waddr  in  6  functional write address.
- wdata  in  80  functional write data.

Behaviour:
- Read: rdata = mem[raddr], combinational with no clock latency. It reflects a write in the cycle after the write edge.
- Write: at a rising edge, if wen & !HALT & !RAM$SCAN then mem[waddr] <= wdata.
- Memory contents are not affected by reset. They are X until written or loaded.
- Reset: asynchronously clears the scan counter, the dump pipeline registers and RAM$SDO to 0.
- Chain order: scan word 2a = mem[a][63:0], scan word 2a+1 = {48'b0, mem[a][79:64]}, for a = 0..63 ascending. Index 0 is transferred first.
- Scan counter (8 bits):
  - cleared at every rising edge where RAM$SCAN = 0;
  - increments at each rising edge with RAM$SCAN = 1;
  - saturates at CHAIN_WORDS+1.
- Dump (SCAN=1, DIR=0): 2-cycle latency.
  - Edge 1 after SCAN rises: registers address/chunk select 0.
  - Edge k+2: RAM$SDO <= scan word k.
  - The host samples word k after k+2 edges with SCAN held high.
  - Past word 127, SDO holds 0.
  - Dump never modifies memory.
- Load (SCAN=1, DIR=1):
  - Edge k (0-based) with SCAN high captures SDI as scan word k.
  - An even k latches the low 64 bits into a holding register.
  - An odd k writes mem[(k-1)/2] <= {SDI[15:0], held low}. SDI[63:16] is ignored on odd words.
  - Edges beyond word 127 while SCAN is still high are ignored; no writes occur.
- DIR changing while SCAN = 1 is illegal. Behaviour is then undefined, but memory must not be corrupted outside the addressed word.
- Reset mid-scan aborts the transfer. The next scan restarts at word 0.
- SCAN is used only while HALT = 1. It is not internally qualified by HALT.

Decomposition:
- Shared package emu_scan_pkg holds: ADDR_WIDTH, DATA_WIDTH, SCAN_WIDTH, CHUNKS, CHAIN_WORDS, and the counter-width function.
- Sub-module emu_ram_scan_ctrl contains:
  - the counter;
  - chunk select;
  - the load holding register;
  - the dump pipeline;
  - the scan write-port mux.
- The top level holds the memory array and the functional port logic.

Test Plan:
1. Write mem[j] = pattern j for j = 0..63, then read each address. Required: rdata equals the written value in the same cycle (combinational).
2. With HALT=1 and wen=1, write mem[5] = 80'hA. Required: mem[5] is unchanged.
3. Write mem[0] = 80'h1234_0000000000000001, then dump with HALT=1, SCAN=1, DIR=0 for 2+128 edges. Required: word 0 = 64'h1, word 1 = 64'h1234, and all 128 words match the chain order.
4. Repeat for 4 rounds: write random data, dump and save the chain. Then restore each saved chain (SCAN=1, DIR=1, 128 words plus 1 extra edge), release HALT and read all 64 addresses. Required: each read equals that round's written data exactly.
5. Load a chain whose odd words carry nonzero SDI[63:16]. Required: the upper bits are ignored and mem[a][79:64] = SDI[15:0].
6. Assert reset mid-dump after 10 words, then rescan. Required: SDO restarts from word 0 and memory contents are intact.
